// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared encodings and constants for the instruction-fetch block.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int INSTR_WIDTH = 32;

    // Fetch controller state encoding
    localparam logic [1:0] c_ST_RESET = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_BUSY  = 2'd2;
    localparam logic [1:0] c_ST_DRAIN = 2'd3;

    // Redirect source encoding
    localparam logic [1:0] c_SRC_NONE   = 2'd0;
    localparam logic [1:0] c_SRC_CSR    = 2'd1;
    localparam logic [1:0] c_SRC_JUMP   = 2'd2;
    localparam logic [1:0] c_SRC_BRANCH = 2'd3;

    // Trap/xRET outranks jump, which outranks a taken branch.
    function automatic logic [1:0] redirect_src(input logic csr_sel,
                                                input logic jump,
                                                input logic taken);
        if (csr_sel)
            return c_SRC_CSR;
        else if (jump)
            return c_SRC_JUMP;
        else if (taken)
            return c_SRC_BRANCH;
        return c_SRC_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Purpose  : Two-entry {pc, instr} FIFO between instruction memory and decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_clear,
    input  logic [PC_W-1:0]   i_push_pc,
    input  logic [DATA_W-1:0] i_push_data,
    output logic [1:0]        o_count,
    output logic              o_head_valid,
    output logic [PC_W-1:0]   o_head_pc,
    output logic [DATA_W-1:0] o_head_data
);

    logic [1:0]        r_count;
    logic [PC_W-1:0]   r_head_pc;
    logic [DATA_W-1:0] r_head_data;
    logic [PC_W-1:0]   r_tail_pc;
    logic [DATA_W-1:0] r_tail_data;
    logic              w_pop;
    logic              w_push;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    // Shift-style storage: the head entry always sits in the head registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= 2'd0;
            r_head_pc   <= '0;
            r_head_data <= '0;
            r_tail_pc   <= '0;
            r_tail_data <= '0;
        end else if (i_clear) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head_pc   <= i_push_pc;
                        r_head_data <= i_push_data;
                    end else begin
                        r_tail_pc   <= i_push_pc;
                        r_tail_data <= i_push_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head_pc   <= r_tail_pc;
                    r_head_data <= r_tail_data;
                    r_count     <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head_pc   <= i_push_pc;
                        r_head_data <= i_push_data;
                    end else begin
                        r_head_pc   <= r_tail_pc;
                        r_head_data <= r_tail_data;
                        r_tail_pc   <= i_push_pc;
                        r_tail_data <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_count      = r_count;
    assign o_head_valid = (r_count != 2'd0);
    assign o_head_pc    = r_head_pc;
    assign o_head_data  = r_head_data;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Fetch PC sequencing, imem handshake and redirect/stall handling.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                   OPD_WIDTH = 32,
    parameter int                   PC_WIDTH  = 12,
    parameter logic [OPD_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   csr_sel,
    input  logic                   jump,
    input  logic                   branch,
    input  logic [OPD_WIDTH-1:0]   comp_result,
    input  logic [OPD_WIDTH-1:0]   alu_result,
    input  logic [OPD_WIDTH-1:0]   csr_out,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [OPD_WIDTH-1:0]   instr_pc,
    output logic                   flush,
    output logic [OPD_WIDTH-1:0]   pc_out
);

    logic [1:0]           r_state;
    logic [OPD_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0]  r_addr;
    logic                 r_flush;

    logic [1:0]           w_count;
    logic [1:0]           w_count_after_pop;
    logic [1:0]           w_src;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_taken;
    logic                 w_redirect;
    logic                 w_req;
    logic                 w_ack;
    logic [OPD_WIDTH-1:0] w_target_raw;
    logic [OPD_WIDTH-1:0] w_target;

    assign w_pop             = instr_valid & ~stall;
    assign w_count_after_pop = w_count - {1'b0, w_pop};
    assign w_taken           = branch && (comp_result == OPD_WIDTH'(1));
    assign w_src             = redirect_src(csr_sel, jump, w_taken);
    assign w_redirect        = (r_state != c_ST_RESET) && (w_src != c_SRC_NONE);
    assign w_target_raw      = (w_src == c_SRC_CSR) ? csr_out : alu_result;
    assign w_target          = w_target_raw & ~OPD_WIDTH'(3);

    // A redirect in FETCH suppresses the request so nothing is left in flight.
    always_comb begin
        w_req = 1'b0;
        case (r_state)
            c_ST_FETCH:            w_req = !w_redirect && (w_count_after_pop <= 2'd1);
            c_ST_BUSY, c_ST_DRAIN: w_req = 1'b1;
            default:               w_req = 1'b0;
        endcase
    end

    assign w_ack  = imem_ack & w_req;
    assign w_push = w_ack && !w_redirect &&
                    ((r_state == c_ST_FETCH) || (r_state == c_ST_BUSY));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RESET;
            r_pc    <= RESET_PC;
            r_addr  <= '0;
            r_flush <= 1'b0;
        end else begin
            r_flush <= w_redirect;
            case (r_state)
                c_ST_RESET: r_state <= c_ST_FETCH;
                c_ST_FETCH: begin
                    r_addr <= r_pc[PC_WIDTH-1:0];
                    if (w_redirect)
                        r_pc <= w_target;
                    else if (w_req) begin
                        if (w_ack)
                            r_pc <= r_pc + OPD_WIDTH'(4);
                        else
                            r_state <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    if (w_redirect) begin
                        r_pc    <= w_target;
                        r_state <= w_ack ? c_ST_FETCH : c_ST_DRAIN;
                    end else if (w_ack) begin
                        r_pc    <= r_pc + OPD_WIDTH'(4);
                        r_state <= c_ST_FETCH;
                    end
                end
                c_ST_DRAIN: begin
                    // r_addr still holds the abandoned address until its ack.
                    if (w_redirect)
                        r_pc <= w_target;
                    if (w_ack)
                        r_state <= c_ST_FETCH;
                end
                default: r_state <= c_ST_RESET;
            endcase
        end
    end

    fetch_buffer #(
        .PC_W   (OPD_WIDTH),
        .DATA_W (INSTR_WIDTH)
    ) u_buffer (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_clear      (w_redirect),
        .i_push_pc    (r_pc),
        .i_push_data  (imem_rdata),
        .o_count      (w_count),
        .o_head_valid (instr_valid),
        .o_head_pc    (instr_pc),
        .o_head_data  (instr)
    );

    assign imem_req  = w_req;
    assign imem_addr = (r_state == c_ST_FETCH) ? r_pc[PC_WIDTH-1:0] : r_addr;
    assign flush     = r_flush;
    assign pc_out    = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Scoreboard bench for fetch_ctrl with a variable-latency memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] w;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        csr_sel = 1'b0;
    logic        jump = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] comp_result = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] csr_out = '0;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        flush;
    logic [31:0] pc_out;

    int   n_chk = 0;
    int   n_fail = 0;
    int   mem_lat = 0;
    int   wait_cnt = 0;
    exp_t sb[$];

    fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .csr_sel     (csr_sel),
        .jump        (jump),
        .branch      (branch),
        .comp_result (comp_result),
        .alu_result  (alu_result),
        .csr_out     (csr_out),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .flush       (flush),
        .pc_out      (pc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [11:0] a);
        return {20'hC0DE0, a};
    endfunction

    // Memory: acks once a request has been held for mem_lat cycles.
    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack)
            wait_cnt <= 0;
        else
            wait_cnt <= wait_cnt + 1;
    end
    assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
    assign imem_rdata = word_of(imem_addr);

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        stall = 0; csr_sel = 0; jump = 0; branch = 0;
        comp_result = '0; alu_result = '0; csr_out = '0;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0b want 0", imem_req); end
        n_chk++; if (imem_addr !== 12'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 000", imem_addr); end
        n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", instr_valid); end
        n_chk++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", instr); end
        n_chk++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
        n_chk++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %0b want 0", flush); end
        n_chk++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", pc_out); end
    endtask

    task automatic test_zero_wait();
        exp_t e;
        mem_lat = 0;
        reset_dut();
        for (int i = 0; i < 6; i++) sb.push_back('{pc: 32'(4 * i), w: word_of(12'(4 * i))});
        @(negedge clk);
        n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL zw_c1_req: got %0b want 0", imem_req); end
        next_cycle();
        @(negedge clk);
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 12'h0) begin n_fail++; $display("FAIL zw_c2_req: got %0b@%h want 1@000", imem_req, imem_addr); end
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr !== e.w) begin
                n_fail++; $display("FAIL zw_stream: got v%0b %h/%h want v1 %h/%h", instr_valid, instr_pc, instr, e.pc, e.w);
            end
        end
    endtask

    task automatic test_latency_stall();
        exp_t e;
        int   acks = 0;
        logic [11:0] exp_addr = 12'h0;
        mem_lat = 3;
        reset_dut();
        stall = 1;
        for (int i = 0; i < 6; i++) sb.push_back('{pc: 32'(4 * i), w: word_of(12'(4 * i))});
        for (int i = 0; i < 40 && acks < 2; i++) begin
            @(negedge clk);
            if (imem_req) begin
                n_chk++; if (imem_addr !== exp_addr) begin n_fail++; $display("FAIL ls_fill_addr: got %h want %h", imem_addr, exp_addr); end
                if (imem_ack) begin acks++; exp_addr += 12'h4; end
            end
            next_cycle();
        end
        n_chk++; if (acks != 2) begin n_fail++; $display("FAIL ls_fill_timeout: got %0d acks want 2", acks); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++; if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL ls_full_req: got req %0b valid %0b want req 0 valid 1", imem_req, instr_valid); end
            next_cycle();
        end
        stall = 0;
        for (int i = 0; i < 60 && sb.size() > 0; i++) begin
            @(negedge clk);
            if (imem_req) begin
                n_chk++; if (imem_addr !== exp_addr) begin n_fail++; $display("FAIL ls_addr: got %h want %h", imem_addr, exp_addr); end
                if (imem_ack) exp_addr += 12'h4;
            end
            if (instr_valid) begin
                e = sb.pop_front();
                n_chk++; if (instr_pc !== e.pc || instr !== e.w) begin n_fail++; $display("FAIL ls_stream: got %h/%h want %h/%h", instr_pc, instr, e.pc, e.w); end
            end
            next_cycle();
        end
        n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL ls_drain_timeout: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_jump();
        exp_t e;
        mem_lat = 0;
        reset_dut();
        repeat (4) next_cycle();
        jump = 1; alu_result = 32'h103;
        @(negedge clk);
        next_cycle();
        jump = 0; alu_result = '0;
        sb.push_back('{pc: 32'h100, w: word_of(12'h100)});
        sb.push_back('{pc: 32'h104, w: word_of(12'h104)});
        @(negedge clk);
        n_chk++; if (flush !== 1'b1) begin n_fail++; $display("FAIL jmp_flush: got %0b want 1", flush); end
        n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL jmp_empty: got %0b want 0", instr_valid); end
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 12'h100) begin n_fail++; $display("FAIL jmp_addr: got %0b@%h want 1@100", imem_req, imem_addr); end
        n_chk++; if (pc_out !== 32'h100) begin n_fail++; $display("FAIL jmp_pc: got %h want 00000100", pc_out); end
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            @(negedge clk);
            if (i == 0) begin
                n_chk++; if (flush !== 1'b0) begin n_fail++; $display("FAIL jmp_flush_once: got %0b want 0", flush); end
            end
            e = sb.pop_front();
            n_chk++; if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr !== e.w) begin n_fail++; $display("FAIL jmp_stream: got v%0b %h/%h want v1 %h/%h", instr_valid, instr_pc, instr, e.pc, e.w); end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        mem_lat = 0;
        reset_dut();
        for (int i = 0; i < 5; i++) sb.push_back('{pc: 32'(4 * i), w: word_of(12'(4 * i))});
        next_cycle();
        alu_result = 32'h40;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            branch = (i == 2) || (i == 4);
            comp_result = (i == 4) ? 32'd1 : 32'd0;
            @(negedge clk);
            if (i == 3) begin
                n_chk++; if (flush !== 1'b0) begin n_fail++; $display("FAIL br_not_taken_flush: got %0b want 0", flush); end
            end
            e = sb.pop_front();
            n_chk++; if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr !== e.w) begin n_fail++; $display("FAIL br_stream: got v%0b %h/%h want v1 %h/%h", instr_valid, instr_pc, instr, e.pc, e.w); end
        end
        next_cycle();
        branch = 0; comp_result = '0;
        sb.push_back('{pc: 32'h40, w: word_of(12'h040)});
        @(negedge clk);
        n_chk++; if (flush !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL br_taken_flush: got flush %0b valid %0b want 1 0", flush, instr_valid); end
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 12'h040) begin n_fail++; $display("FAIL br_taken_addr: got %0b@%h want 1@040", imem_req, imem_addr); end
        next_cycle();
        @(negedge clk);
        e = sb.pop_front();
        n_chk++; if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr !== e.w) begin n_fail++; $display("FAIL br_target: got v%0b %h/%h want v1 %h/%h", instr_valid, instr_pc, instr, e.pc, e.w); end
    endtask

    task automatic test_drain();
        exp_t e;
        logic seen = 1'b0;
        mem_lat = 3;
        reset_dut();
        next_cycle();
        @(negedge clk);
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== 12'h0) begin n_fail++; $display("FAIL dr_first_req: got %0b@%h want 1@000", imem_req, imem_addr); end
        next_cycle();
        jump = 1; alu_result = 32'h200;
        next_cycle();
        alu_result = 32'h300;
        @(negedge clk);
        n_chk++; if (flush !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 12'h0 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL dr_hold1: got f%0b r%0b %h v%0b want f1 r1 000 v0", flush, imem_req, imem_addr, instr_valid);
        end
        next_cycle();
        jump = 0; alu_result = '0;
        sb.push_back('{pc: 32'h300, w: word_of(12'h300)});
        @(negedge clk);
        n_chk++; if (flush !== 1'b1 || imem_ack !== 1'b1 || imem_addr !== 12'h0 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL dr_hold2: got f%0b a%0b %h v%0b want f1 a1 000 v0", flush, imem_ack, imem_addr, instr_valid);
        end
        next_cycle();
        @(negedge clk);
        n_chk++; if (flush !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 12'h300 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL dr_retarget: got f%0b r%0b %h v%0b want f0 r1 300 v0", flush, imem_req, imem_addr, instr_valid);
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            next_cycle();
            @(negedge clk);
            if (instr_valid) begin
                seen = 1'b1;
                e = sb.pop_front();
                n_chk++; if (instr_pc !== e.pc || instr !== e.w) begin n_fail++; $display("FAIL dr_target: got %h/%h want %h/%h", instr_pc, instr, e.pc, e.w); end
            end
        end
        n_chk++; if (!seen) begin n_fail++; $display("FAIL dr_timeout: got no instr want pc 00000300"); end
    endtask

    task automatic test_csr_wrap();
        exp_t e;
        mem_lat = 0;
        reset_dut();
        repeat (3) next_cycle();
        csr_sel = 1; jump = 1; csr_out = 32'hFFE; alu_result = 32'h500;
        @(negedge clk);
        next_cycle();
        csr_sel = 0; jump = 0; csr_out = '0; alu_result = '0;
        sb.push_back('{pc: 32'hFFC, w: word_of(12'hFFC)});
        sb.push_back('{pc: 32'h1000, w: word_of(12'h000)});
        @(negedge clk);
        n_chk++; if (flush !== 1'b1 || imem_addr !== 12'hFFC || pc_out !== 32'hFFC) begin
            n_fail++; $display("FAIL csr_target: got f%0b %h pc %h want f1 ffc pc 00000ffc", flush, imem_addr, pc_out);
        end
        next_cycle();
        @(negedge clk);
        n_chk++; if (imem_addr !== 12'h000 || pc_out !== 32'h1000) begin n_fail++; $display("FAIL csr_wrap: got %h pc %h want 000 pc 00001000", imem_addr, pc_out); end
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin next_cycle(); @(negedge clk); end
            e = sb.pop_front();
            n_chk++; if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr !== e.w) begin n_fail++; $display("FAIL csr_stream: got v%0b %h/%h want v1 %h/%h", instr_valid, instr_pc, instr, e.pc, e.w); end
        end
    endtask

    task automatic test_reset_mid();
        mem_lat = 3;
        reset_dut();
        next_cycle();
        next_cycle();
        rst = 1;
        next_cycle();
        @(negedge clk);
        n_chk++; if (imem_req !== 1'b0 || flush !== 1'b0 || pc_out !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid: got r%0b f%0b pc %h want r0 f0 pc 0", imem_req, flush, pc_out);
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency_stall();
        test_jump();
        test_branch();
        test_drain();
        test_csr_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that sequences the program counter between reset, sequential fetch and redirects. It owns the fetch PC register, drives the instruction-memory request/acknowledge handshake and buffers up to two fetched instructions toward decode. It resolves the redirect sources from execute (trap/CSR, jump, taken branch) and absorbs stalls from the hazard unit. It sits between the instruction memory and the decode stage.

## Interface
- OPD_WIDTH, 32, operand/PC datapath width
- PC_WIDTH, 12, instruction-memory address width
- RESET_PC, 0, fetch address after reset
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  synchronous, active-high reset
- stall  in  1  decode cannot accept the head instruction this cycle
- csr_sel  in  1  trap/xRET redirect to csr_out
- jump  in  1  unconditional redirect to alu_result
- branch  in  1  conditional branch in execute
- comp_result  in  OPD_WIDTH  branch is taken iff this value == 1
- alu_result  in  OPD_WIDTH  jump/branch target
- csr_out  in  OPD_WIDTH  trap/return target
- imem_req  out  1  fetch request
- imem_addr  out  PC_WIDTH  fetch address, stable while imem_req is high
- imem_ack  in  1  response valid; may occur in the same cycle as imem_req
- imem_rdata  in  32  instruction word, sampled when imem_ack is high
- instr_valid  out  1  buffer head is valid
- instr  out  32  buffer head instruction
- instr_pc  out  OPD_WIDTH  PC of the buffer head
- flush  out  1  one-cycle pulse after an accepted redirect
- pc_out  out  OPD_WIDTH  current fetch PC

## Operation
- Redirect: redirect = csr_sel | jump | (branch & comp_result == 1). Priority is csr_sel, then jump/branch.
  - Target is csr_out or alu_result, truncated to OPD_WIDTH, with bits [1:0] forced to 0.
  - Redirect is evaluated every cycle in every non-RESET state. It overrides stall.
- Buffer: 2-entry FIFO, count 0..2.
  - Head pops at a clock edge when instr_valid & !stall.
  - Entries are written from imem_rdata on an acked, non-discarded response.
  - Redirect clears the FIFO at the same edge.
- States:
  - RESET: held while rst. The first cycle after rst falls keeps imem_req = 0, then goes to FETCH.
  - FETCH: imem_req = 0 until count <= 1 (counted after this cycle's pop). Then imem_req = 1 with imem_addr = pc[PC_WIDTH-1:0] and the state moves to BUSY.
    - If imem_ack arrives in the same cycle, the response is handled as in BUSY and the state stays FETCH.
  - BUSY: imem_req held at 1 and imem_addr frozen until imem_ack.
    - On ack: push the word with instr_pc = pc, set pc <= pc + 4, go to FETCH.
  - DRAIN: entered on a redirect while a request is unacked. imem_req and imem_addr are held at the old address.
    - On ack, the data is discarded and the state moves to FETCH at the pending target.
    - A further redirect while in DRAIN replaces the pending target.
- Redirect in FETCH, or coinciding with an ack:
  - Any acked data is discarded.
  - pc <= target, FIFO cleared, flush = 1 next cycle.
  - Next state is FETCH.
- Redirect in BUSY without ack: pc <= target, FIFO cleared, flush pulses, next state is DRAIN.
- At most one request is outstanding at any time.
- PC arithmetic is modulo 2^OPD_WIDTH; imem_addr takes the low PC_WIDTH bits, so it wraps silently.

## Timing
- Reset values:
  - imem_req = 0, imem_addr = 0, instr_valid = 0, instr = 0, instr_pc = 0, flush = 0.
  - pc_out = RESET_PC, count = 0.
- First imem_req rises in the second cycle after rst deasserts.
- With zero-wait memory (ack in the same cycle) and no stall, throughput is one instruction per cycle.
- instr_valid rises the cycle after the ack.
- Redirect to first request at the new target: 1 cycle, or 1 cycle after the drain ack when in DRAIN.
- flush is exactly one cycle per redirect. Redirects in consecutive cycles give flush high in consecutive cycles, and the last target wins.
- rst mid-request abandons the transaction immediately. Memory is reset by the same rst.
- Stall while count = 2 keeps imem_req at 0. Stall never changes pc.

## Structure
- Shared package fetch_pkg holds:
  - the state encoding (RESET, FETCH, BUSY, DRAIN);
  - the redirect-source encoding (NONE, CSR, JUMP, BRANCH);
  - the INSTR_WIDTH = 32 constant.
- Sub-module fetch_buffer: 2-entry FIFO of {pc, instr} with push, pop, clear, count and head outputs. The FSM, PC register and redirect logic live in fetch_ctrl.

## Test plan
- Reset release, zero-wait memory, no stall:
  - imem_req rises in cycle 2 at addr 0.
  - instr_valid follows with instr_pc 0, 4, 8, one per cycle.
- Memory with 3-cycle ack latency, stall held 5 cycles with count = 2:
  - imem_addr stays stable until ack.
  - No request is issued while count = 2.
  - No instruction is lost or duplicated.
- jump = 1, alu_result = 0x103, in FETCH:
  - flush pulses once and the FIFO empties.
  - Next imem_addr = 0x100.
- branch = 1 with comp_result = 0 gives no redirect. branch = 1 with comp_result = 1 and alu_result = 0x40 redirects to 0x40.
- Redirect while BUSY with ack delayed 2 cycles:
  - The old address is held and its data is discarded (instr_valid stays 0).
  - Next request is at the target.
  - A second redirect during DRAIN wins.
- csr_sel and jump in the same cycle: target = csr_out. With PC at 0xFFC and PC_WIDTH = 12, the next sequential imem_addr = 0x000.
